ram_host_port: RTL

Host-side command engine driving port B of the CPU's 16K x 16 dual-port program/data RAM. It accepts a byte stream from the host link (USB/serial bridge) through a valid/ready handshake and decodes set-address, write-burst and read-burst commands. Words are written to or read from the RAM with an auto-incrementing address, and read data returns as a byte stream. The CPU keeps exclusive use of port A; this block owns ab/dib/dob/ceb/web.

---
 rtl/ram_host_port_if.sv | 28 ++
 rtl/ram_host_port.sv | 125 ++++++++++++
 2 files changed

// File: rtl/ram_host_port_if.sv
// Host link and RAM port-B signal bundle for ram_host_port.
// slave: the command engine; master: host link plus RAM side.
interface ram_host_port_if #(
    parameter int ADDR_W = 14
);
    logic [7:0]        rxd;
    logic              rxv;
    logic              rxr;
    logic [7:0]        txd;
    logic              txv;
    logic              txr;
    logic [ADDR_W-1:0] ab;
    logic [15:0]       dib;
    logic [15:0]       dob;
    logic              ceb;
    logic              web;
    logic              busy;

    modport slave (
        input  rxd, rxv, txr, dob,
        output rxr, txd, txv, ab, dib, ceb, web, busy
    );

    modport master (
        output rxd, rxv, txr, dob,
        input  rxr, txd, txv, ab, dib, ceb, web, busy
    );
endinterface

// File: rtl/ram_host_port.sv
// Host command engine for RAM port B: set-address, write and read bursts.
// Ports: clk, rst (sync, active-high), bus (rx/tx byte streams, RAM port B, busy).
module ram_host_port #(
    parameter int ADDR_W = 14
) (
    input  logic          clk,
    input  logic          rst,
    ram_host_port_if.slave bus
);
    typedef enum logic [3:0] {
        IDLE, ALO, WCNT, WLO, WHI, RCNT, RREQ, RWAIT, RLO, RHI
    } state_t;

    state_t state, state_n;

    logic [ADDR_W-1:0] addr;
    logic [ADDR_W-9:0] ahi;
    logic [7:0]        count;
    logic [7:0]        lo;
    logic [7:0]        txd;
    logic [15:0]       rdata;
    logic [15:0]       dib;
    logic              wstb;
    logic              txv;
    logic              rxr;
    logic              acc;
    logic              more;

    // Host input is only taken outside the read-return phase.
    always_comb begin
        rxr = 1'b1;
        unique case (state)
            RREQ, RWAIT, RLO, RHI: rxr = 1'b0;
            default:               rxr = 1'b1;
        endcase
    end

    assign acc  = bus.rxv & rxr;
    assign more = (count != 8'd0);

    always_comb begin
        state_n = state;
        unique case (state)
            IDLE: begin
                if (acc) begin
                    unique case (bus.rxd[7:6])
                        2'b00:   state_n = ALO;
                        2'b01:   state_n = WCNT;
                        2'b10:   state_n = RCNT;
                        default: state_n = IDLE;
                    endcase
                end
            end
            ALO:   if (acc) state_n = IDLE;
            WCNT:  if (acc) state_n = WLO;
            WLO:   if (acc) state_n = WHI;
            WHI:   if (acc) state_n = more ? WLO : IDLE;
            RCNT:  if (acc) state_n = RREQ;
            RREQ:  state_n = RWAIT;
            RWAIT: state_n = RLO;
            RLO:   if (bus.txr) state_n = RHI;
            RHI:   if (bus.txr) state_n = more ? RREQ : IDLE;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            addr  <= '0;
            ahi   <= '0;
            count <= '0;
            lo    <= '0;
            rdata <= '0;
            dib   <= '0;
            wstb  <= 1'b0;
            txv   <= 1'b0;
            txd   <= '0;
        end else begin
            state <= state_n;
            // Strobe fires the cycle after the high byte is taken.
            wstb  <= (state == WHI) && acc;
            txv   <= (state_n == RLO) || (state_n == RHI);

            // A strobe cycle never overlaps ALO or RWAIT, so these
            // address updates cannot collide.
            if (wstb || state == RWAIT)
                addr <= addr + ADDR_W'(1);
            // The high part is parked until the low byte arrives so the
            // full address changes in one step.
            if (state == IDLE && acc)
                ahi <= bus.rxd[ADDR_W-9:0];
            if (state == ALO && acc)
                addr <= {ahi, bus.rxd};

            if ((state == WCNT || state == RCNT) && acc)
                count <= bus.rxd;
            if (state == WLO && acc)
                lo <= bus.rxd;
            if (state == WHI && acc) begin
                dib <= {bus.rxd, lo};
                if (more)
                    count <= count - 8'd1;
            end

            if (state == RWAIT) begin
                rdata <= bus.dob;
                txd   <= bus.dob[7:0];
            end
            if (state == RLO && bus.txr)
                txd <= rdata[15:8];
            if (state == RHI && bus.txr && more)
                count <= count - 8'd1;
        end
    end

    assign bus.rxr  = rxr;
    assign bus.txd  = txd;
    assign bus.txv  = txv;
    assign bus.ab   = addr;
    assign bus.dib  = dib;
    assign bus.ceb  = wstb | (state == RREQ);
    assign bus.web  = wstb;
    assign bus.busy = (state != IDLE);
endmodule
